ifu_fetch: RTL

Instruction fetch stage directly upstream of the decode stage in the RV64 core. It owns the architectural PC and issues one 32-bit instruction request at a time to instruction memory over a valid/ready request channel and a valid-only response channel. It presents the fetched instruction and its PC to decode over a valid/ready handshake. It accepts redirects for jal, jalr, taken branch, ecall and mret, which carry a target PC and squash any in-flight fetch.

---
 rtl/core_pkg.sv | 14 +
 rtl/ifu_fetch_if.sv | 29 ++
 rtl/ifu_fetch.sv | 81 ++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states and reset constants.
package core_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: imem request/response channels and the decode handshake.
interface ifu_fetch_if;
    import core_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        output id_valid, id_inst, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  id_valid, id_inst, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output id_ready
    );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, one outstanding imem request,
// registered instruction/PC bundle to decode, redirect with squash.
module ifu_fetch #(
    parameter logic [core_pkg::XLEN-1:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [core_pkg::XLEN-1:0] redirect_pc,
    ifu_fetch_if.master               bus
);
    import core_pkg::*;

    ifu_state_e      state;
    logic [XLEN-1:0] pc;
    logic            kill;
    logic            id_valid_q;
    logic [31:0]     id_inst_q;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] target;

    assign target = redirect_pc & ~XLEN'(3);

    assign bus.imem_req_valid = (state == S_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_inst        = id_inst_q;
    assign bus.id_pc          = id_pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= INST_NOP;
            id_pc_q    <= RESET_PC;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (redirect_valid)
                        pc <= target;
                    // a request launched alongside a redirect fetches a stale PC
                    if (bus.imem_req_ready) begin
                        state <= S_WAIT;
                        kill  <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        state <= S_REQ;
                        kill  <= 1'b0;
                        if (redirect_valid) begin
                            pc <= target;
                        end else if (!kill) begin
                            id_inst_q  <= bus.imem_rsp_data;
                            id_pc_q    <= pc;
                            id_valid_q <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc   <= target;
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || bus.id_ready) begin
                        pc         <= redirect_valid ? target : pc + XLEN'(4);
                        id_valid_q <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                    kill  <= 1'b0;
                end
            endcase
        end
    end

endmodule
